// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32I load/store unit in front of a multi-cycle word memory.
// Optional LSU_MISALIGN_TRAP_EN: misaligned or invalid requests answer with rsp_err.
module lsu_mem_port #(
    parameter int MEM_WORDS   = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [2:0]                   req_funct3,
    input  logic [31:0]                  req_addr,
    input  logic [31:0]                  req_wdata,
    output logic                         rsp_valid,
    output logic [31:0]                  rsp_rdata,
    output logic                         rsp_err,
    output logic                         mem_en,
    output logic [3:0]                   mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [1:0] WAIT_INIT =
        2'(MEM_LATENCY >= 2 ? MEM_LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [1:0]    cnt_q;
    logic          accept;
    logic          sample;
    logic          trap_in;
    logic          unused_addr;

    // Address bits above the memory depth wrap silently.
    assign unused_addr = &{1'b0, req_addr[31:AW+2]};

    function automatic logic [31:0] load_ext(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    load_ext = {{24{b[7]}}, b};
            3'd1:    load_ext = {{16{h[15]}}, h};
            3'd2:    load_ext = w;
            3'd4:    load_ext = {24'b0, b};
            3'd5:    load_ext = {16'b0, h};
            default: load_ext = '0;
        endcase
    endfunction

    function automatic logic [3:0] st_mask(
        input logic [1:0] off,
        input logic [2:0] f3
    );
        case (f3)
            3'd0:    st_mask = 4'b0001 << off;
            3'd1:    st_mask = off[1] ? 4'b1100 : 4'b0011;
            3'd2:    st_mask = 4'b1111;
            default: st_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] st_data(
        input logic [31:0] d,
        input logic [2:0]  f3
    );
        case (f3)
            3'd0:    st_data = {4{d[7:0]}};
            3'd1:    st_data = {2{d[15:0]}};
            default: st_data = d;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;

    function automatic logic bad_req(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic ok_f3;
        logic mis;
        ok_f3 = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
        mis   = (f3[1:0] == 2'd1 && off[0]) ||
                (f3[1:0] == 2'd2 && off != 2'd0);
        bad_req = !ok_f3 || mis;
    endfunction

    assign trap_in = bad_req(req_we, req_funct3, req_addr[1:0]);
    assign rsp_err = rsp_valid & err_q;
`else
    assign trap_in = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_en    = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
            end
            S_ACCESS: begin
                mem_en = 1'b1;
                if (we_q) begin
                    state_d = S_RESP;
                end else if (MEM_LATENCY <= 1) begin
                    sample  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    sample  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                req_ready = 1'b1;
                rsp_valid = 1'b1;
                accept    = req_valid;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Trapped requests bypass memory and answer in the next cycle.
        if (accept) begin
            state_d = trap_in ? S_RESP : S_ACCESS;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                err_q   <= trap_in;
`endif
            end
            if (state_q == S_ACCESS) begin
                cnt_q <= WAIT_INIT;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (sample) begin
                rdata_q <= load_ext(mem_rdata, addr_q[1:0], f3_q);
            end
        end
    end

    assign mem_we    = (mem_en && we_q) ? st_mask(addr_q[1:0], f3_q) : 4'b0;
    assign mem_wdata = (mem_en && we_q) ? st_data(wdata_q, f3_q) : '0;
    assign mem_addr  = mem_en ? addr_q[AW+1:2] : '0;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule
